// File: rtl/debug_pkg.sv
// Shared constants, state encoding and helpers for the host debug unit.
package debug_pkg;

    // Host command bytes (ASCII 'L', 'C', 'S', 'R', 'H').
    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_CLEAR = 8'h52;
    localparam logic [7:0] CMD_HALT  = 8'h48;

    // Report is 2 PC bytes followed by 4 cycle-counter bytes.
    localparam int REPORT_BYTES = 6;
    localparam int REPORT_W     = REPORT_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_CLEAR,
        ST_SEND
    } state_e;

    // A run stops on the pipeline's halt or on a host halt byte; both at once is one stop.
    function automatic logic run_stop(input logic halt, input logic valid, input logic [7:0] data);
        return halt || (valid && (data == CMD_HALT));
    endfunction

endpackage

// File: rtl/debug_unit_if.sv
// UART-side byte stream: receive strobe in, transmit valid/ready handshake out.
interface debug_unit_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // UART side: produces received bytes and accepts bytes to transmit.
    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    // Debug unit side.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/debug_tx_serializer.sv
// Shifts a 48-bit report out MSB byte first over a valid/ready handshake.
module debug_tx_serializer
    import debug_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load_i,
    input  logic [REPORT_W-1:0] data_i,
    input  logic                tx_ready_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    output logic                done_o
);

    logic [REPORT_W-1:0] shift_q, shift_d;
    logic [2:0]          left_q, left_d;
    logic [7:0]          data_q, data_d;
    logic                valid_q, valid_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;

    // Load, present first byte one cycle later, then advance on each accepted byte.
    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        data_d  = data_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        if (load_i) begin
            shift_d = data_i;
            left_d  = 3'(REPORT_BYTES);
            pend_d  = 1'b1;
            valid_d = 1'b0;
        end else if (pend_q) begin
            data_d  = shift_q[REPORT_W-1 -: 8];
            shift_d = shift_q << 8;
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end else if (valid_q && tx_ready_i) begin
            if (left_q == 3'd1) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                left_d  = 3'd0;
            end else begin
                data_d  = shift_q[REPORT_W-1 -: 8];
                shift_d = shift_q << 8;
                left_d  = left_q - 3'd1;
            end
        end
    end

    // Serializer state; reset abandons any partial report.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            left_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;
    assign done_o     = done_q;

endmodule

// File: rtl/debug_unit.sv
// Host debug unit: program loader, run/step enable gating and PC/cycle report.
module debug_unit
    import debug_pkg::*;
#(
    parameter int IMEM_ADDR_W = 10,
    parameter int CYC_W       = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    debug_unit_if.slave            uart,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    input  logic [IMEM_ADDR_W-1:0] pc_in,
    input  logic                   halt_in,
    output logic                   cpu_enable,
    output logic                   cpu_clear,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_hi_q;
    logic [15:0]            words_left_q;
    logic [IMEM_ADDR_W-1:0] word_idx_q;
    logic [1:0]             byte_idx_q;
    logic [23:0]            word_q;
    logic                   step_phase_q;
    logic [CYC_W-1:0]       cyc_q, cyc_d;

    logic                   imem_we_q, imem_we_d;
    logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]            imem_wdata_q, imem_wdata_d;
    logic                   cpu_enable_q, cpu_enable_d;
    logic                   cpu_clear_q, cpu_clear_d;
    logic                   busy_q, busy_d;

    logic                   wr_fire;
    logic                   stop;
    logic                   tx_load;
    logic                   tx_done;
    logic [15:0]            pc_ext;

    assign wr_fire = (state_q == ST_LOAD) && uart.rx_valid && (byte_idx_q == 2'd3);
    assign stop    = run_stop(halt_in, uart.rx_valid, uart.rx_data);
    assign pc_ext  = 16'(pc_in);
    assign tx_load = (state_d == ST_SEND) && (state_q != ST_SEND);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode from commands, load progress, run stop and report completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (uart.rx_valid) begin
                    case (uart.rx_data)
                        CMD_LOAD:  state_d = ST_CNT_HI;
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: state_d = ST_CLEAR;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_CNT_HI: if (uart.rx_valid) state_d = ST_CNT_LO;
            ST_CNT_LO: begin
                if (uart.rx_valid)
                    state_d = ({cnt_hi_q, uart.rx_data} == 16'd0) ? ST_IDLE : ST_LOAD;
            end
            ST_LOAD:  if (wr_fire && (words_left_q == 16'd1)) state_d = ST_IDLE;
            ST_RUN:   if (stop) state_d = ST_SEND;
            ST_STEP:  if (step_phase_q) state_d = ST_SEND;
            ST_CLEAR: state_d = ST_SEND;
            ST_SEND:  if (tx_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the cycle counter.
    always_comb begin
        // Step enables the pipeline in the second STEP cycle only, giving exactly one enabled cycle.
        cpu_enable_d = (state_d == ST_RUN) || ((state_q == ST_STEP) && !step_phase_q);
        cpu_clear_d  = (state_d == ST_CLEAR);
        busy_d       = (state_d != ST_IDLE);
        imem_we_d    = wr_fire;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (wr_fire) begin
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {word_q, uart.rx_data};
        end
        // The report snapshot uses cyc_d so the last enabled cycle is included.
        if (state_q == ST_CLEAR)  cyc_d = '0;
        else if (cpu_enable_q)    cyc_d = cyc_q + CYC_W'(1);
        else                      cyc_d = cyc_q;
    end

    // Output registers; reset drops cpu_enable immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_enable_q <= 1'b0;
            cpu_clear_q  <= 1'b0;
            busy_q       <= 1'b0;
            cyc_q        <= '0;
        end else begin
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_enable_q <= cpu_enable_d;
            cpu_clear_q  <= cpu_clear_d;
            busy_q       <= busy_d;
            cyc_q        <= cyc_d;
        end
    end

    // Load datapath: word count capture, byte assembly and word index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_hi_q     <= '0;
            words_left_q <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            step_phase_q <= 1'b0;
        end else begin
            step_phase_q <= (state_q == ST_STEP) && !step_phase_q;
            if ((state_q == ST_CNT_HI) && uart.rx_valid)
                cnt_hi_q <= uart.rx_data;
            if ((state_q == ST_CNT_LO) && uart.rx_valid) begin
                words_left_q <= {cnt_hi_q, uart.rx_data};
                word_idx_q   <= '0;
                byte_idx_q   <= '0;
            end
            if ((state_q == ST_LOAD) && uart.rx_valid) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                word_q     <= {word_q[15:0], uart.rx_data};
                if (byte_idx_q == 2'd3) begin
                    words_left_q <= words_left_q - 16'd1;
                    word_idx_q   <= word_idx_q + IMEM_ADDR_W'(1);
                end
            end
        end
    end

    debug_tx_serializer u_tx (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tx_load),
        .data_i     ({pc_ext, cyc_d}),
        .tx_ready_i (uart.tx_ready),
        .tx_data_o  (uart.tx_data),
        .tx_valid_o (uart.tx_valid),
        .done_o     (tx_done)
    );

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_enable = cpu_enable_q;
    assign cpu_clear  = cpu_clear_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: stimulus pushes expected writes/report bytes, a monitor pops and compares.
module tb_debug_unit;
    import debug_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [9:0]  pc_in = '0;
    logic        halt_in = 1'b0;
    logic        cpu_enable;
    logic        cpu_clear;
    logic        busy;

    debug_unit_if uart_if();

    debug_unit #(.IMEM_ADDR_W(10), .CYC_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart       (uart_if),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .pc_in      (pc_in),
        .halt_in    (halt_in),
        .cpu_enable (cpu_enable),
        .cpu_clear  (cpu_clear),
        .busy       (busy)
    );

    initial forever #5 clock = ~clock;

    // Scoreboard and reference model state.
    logic [7:0]  tx_exp[$];
    logic [41:0] imem_exp[$];
    logic [31:0] load_words[$];
    logic [31:0] model_cnt = '0;
    int          n_checks = 0;
    int          n_err = 0;
    int          en_count = 0;
    int          clr_count = 0;
    bit          bp_hold = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmit backpressure: random ready, forced low while bp_hold is set.
    initial begin
        uart_if.tx_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            uart_if.tx_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every write strobe and every accepted tx byte.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (cpu_enable) en_count++;
            if (cpu_clear)  clr_count++;
            if (prev_stall) begin
                check("tx_hold_valid", 64'(uart_if.tx_valid), 64'(1));
                check("tx_hold_data", 64'(uart_if.tx_data), 64'(prev_data));
            end
            if (imem_we) begin
                if (imem_exp.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL imem_unexpected: got addr 0x%0h data 0x%0h expected no write", imem_addr, imem_wdata);
                end else begin
                    logic [41:0] e;
                    e = imem_exp.pop_front();
                    check("imem_addr", 64'(imem_addr), 64'(e[41:32]));
                    check("imem_data", 64'(imem_wdata), 64'(e[31:0]));
                end
            end
            if (uart_if.tx_valid && uart_if.tx_ready) begin
                if (tx_exp.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL tx_unexpected: got 0x%0h expected no byte", uart_if.tx_data);
                end else begin
                    check("tx_byte", 64'(uart_if.tx_data), 64'(tx_exp.pop_front()));
                end
            end
            prev_stall = uart_if.tx_valid && !uart_if.tx_ready;
            prev_data  = uart_if.tx_data;
        end
    end

    // Called at a negedge; the byte is sampled on the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        uart_if.rx_data  = b;
        uart_if.rx_valid = 1'b1;
        @(negedge clock);
        uart_if.rx_valid = 1'b0;
    endtask

    task automatic push_report(input logic [9:0] pc);
        logic [15:0] p;
        p = {6'b0, pc};
        tx_exp.push_back(p[15:8]);
        tx_exp.push_back(p[7:0]);
        tx_exp.push_back(model_cnt[31:24]);
        tx_exp.push_back(model_cnt[23:16]);
        tx_exp.push_back(model_cnt[15:8]);
        tx_exp.push_back(model_cnt[7:0]);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy || tx_exp.size() != 0 || imem_exp.size() != 0) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t >= 3000) begin
            n_err++;
            $display("FAIL %s_timeout: got busy=%0d pending_tx=%0d pending_wr=%0d expected idle", name, busy, tx_exp.size(), imem_exp.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        halt_in = 1'b0;
        uart_if.rx_valid = 1'b0;
        model_cnt = '0;
        tx_exp.delete();
        imem_exp.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_step(input logic [9:0] pc);
        int e0;
        pc_in = pc;
        e0 = en_count;
        send_byte(CMD_STEP);
        model_cnt = model_cnt + 32'd1;
        push_report(pc);
        wait_idle("step");
        check("step_enable_cycles", 64'(en_count - e0), 64'(1));
        $display("step pc=0x%03h cnt=0x%08h", pc, model_cnt);
    endtask

    // mode 0: halt_in, 1: halt byte, 2: both together. Stop is sampled d edges after the command.
    task automatic do_run(input logic [9:0] pc, input int d, input int mode);
        int e0;
        pc_in = pc;
        e0 = en_count;
        send_byte(CMD_RUN);
        if (d > 1) repeat (d - 1) @(negedge clock);
        model_cnt = model_cnt + 32'(d);
        push_report(pc);
        if (mode != 1) halt_in = 1'b1;
        if (mode != 0) begin
            uart_if.rx_data  = CMD_HALT;
            uart_if.rx_valid = 1'b1;
        end
        @(negedge clock);
        halt_in = 1'b0;
        uart_if.rx_valid = 1'b0;
        wait_idle("run");
        check("run_enable_cycles", 64'(en_count - e0), 64'(d));
        $display("run pc=0x%03h cycles=%0d stop_mode=%0d cnt=0x%08h", pc, d, mode, model_cnt);
    endtask

    task automatic do_clear(input logic [9:0] pc, input bit bp);
        int c0;
        logic [15:0] p;
        p = {6'b0, pc};
        pc_in = pc;
        c0 = clr_count;
        if (bp) bp_hold = 1'b1;
        send_byte(CMD_CLEAR);
        model_cnt = '0;
        push_report(pc);
        if (bp) begin
            repeat (2) @(negedge clock);
            for (int i = 0; i < 10; i++) begin
                check("bp_tx_valid", 64'(uart_if.tx_valid), 64'(1));
                check("bp_tx_data", 64'(uart_if.tx_data), 64'(p[15:8]));
                @(negedge clock);
            end
            bp_hold = 1'b0;
        end
        wait_idle("clear");
        check("clear_pulses", 64'(clr_count - c0), 64'(1));
        $display("clear pc=0x%03h backpressure=%0d", pc, bp);
    endtask

    // Loads load_words; expected write address is the word index modulo 1024.
    task automatic do_load();
        int n;
        n = load_words.size();
        send_byte(CMD_LOAD);
        send_byte(8'(n >> 8));
        send_byte(8'(n & 255));
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = load_words[i];
            imem_exp.push_back({10'(i % 1024), w});
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        wait_idle("load");
        check("load_busy_after", 64'(busy), 64'(0));
        $display("load words=%0d", n);
    endtask

    task automatic rand_words(input int n);
        load_words.delete();
        for (int i = 0; i < n; i++) load_words.push_back($urandom);
    endtask

    initial begin
        uart_if.rx_valid = 1'b0;
        uart_if.rx_data  = '0;
        repeat (3) @(negedge clock);
        check("rst_tx_data", 64'(uart_if.tx_data), 64'(0));
        check("rst_tx_valid", 64'(uart_if.tx_valid), 64'(0));
        check("rst_imem_we", 64'(imem_we), 64'(0));
        check("rst_imem_addr", 64'(imem_addr), 64'(0));
        check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
        check("rst_cpu_enable", 64'(cpu_enable), 64'(0));
        check("rst_cpu_clear", 64'(cpu_clear), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        @(negedge clock);

        // Directed: two-word load, step, clear under backpressure, run to halt.
        load_words.delete();
        load_words.push_back(32'h12345678);
        load_words.push_back(32'hDEADBEEF);
        do_load();
        do_step(10'h005);
        do_clear(10'h0AB, 1'b1);
        do_run(10'h3FF, 21, 0);

        // Randomized command mix.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: do_step(10'($urandom_range(0, 1023)));
                1: do_run(10'($urandom_range(0, 1023)), int'($urandom_range(1, 30)), int'($urandom_range(0, 2)));
                2: do_clear(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
                3: begin
                    rand_words(int'($urandom_range(0, 4)));
                    do_load();
                end
                default: begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    while (b == CMD_LOAD || b == CMD_RUN || b == CMD_STEP || b == CMD_CLEAR)
                        b = 8'($urandom);
                    send_byte(b);
                    @(negedge clock);
                    check("ignored_byte_busy", 64'(busy), 64'(0));
                    $display("ignored byte 0x%02h", b);
                end
            endcase
        end

        // Reset mid-load: partial word must never be written.
        send_byte(CMD_LOAD);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        check("midload_busy", 64'(busy), 64'(0));
        $display("reset during load");
        repeat (5) @(negedge clock);
        do_step(10'($urandom_range(0, 1023)));

        // Address wrap: 1025 words, last lands at address 0.
        rand_words(1025);
        do_load();

        // Reset during a run: enable must drop without waiting for a clock.
        pc_in = 10'h100;
        send_byte(CMD_RUN);
        repeat (4) @(negedge clock);
        check("run_enable_before_reset", 64'(cpu_enable), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("async_enable_drop", 64'(cpu_enable), 64'(0));
        check("async_busy_drop", 64'(busy), 64'(0));
        model_cnt = '0;
        tx_exp.delete();
        imem_exp.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        $display("reset during run");
        do_step(10'h2C3);

        repeat (20) @(negedge clock);
        check("final_tx_pending", 64'(tx_exp.size()), 64'(0));
        check("final_wr_pending", 64'(imem_exp.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #600000;
        n_checks++;
        n_err++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
